// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with branch redirect, flush window and halt
module pc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt,
  input  logic        br_valid,
  input  logic [1:0]  BS,
  input  logic        PS,
  input  logic        Z,
  input  logic [31:0] br_pc_1,
  input  logic [15:0] br_offset,
  input  logic [31:0] RAA,
  output logic [31:0] PC,
  output logic [31:0] PC_1,
  output logic        fetch_valid,
  output logic        flush,
  output logic        taken,
  output logic [15:0] taken_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q;
  logic        flush_cnt;
  logic [31:0] bra;
  logic [31:0] target;
  logic        redirect;
  logic        take;

  assign bra   = br_pc_1 + {{16{br_offset[15]}}, br_offset};
  assign PC_1  = PC + 32'd1;
  assign state = state_q;

  always_comb begin
    redirect = 1'b0;
    target   = bra;
    case (BS)
      2'b01:   redirect = PS ^ Z;
      2'b10: begin
        redirect = 1'b1;
        target   = RAA;
      end
      2'b11:   redirect = 1'b1;
      default: redirect = 1'b0;
    endcase
  end

  // Branches are only honoured in RUN; the unused encoding behaves as RUN.
  assign take = br_valid && redirect && (state_q != FLUSH) && (state_q != HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      PC          <= 32'd0;
      state_q     <= RUN;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      taken       <= 1'b0;
      taken_cnt   <= 16'd0;
      flush_cnt   <= 1'b0;
    end else if (halt) begin
      state_q     <= HALT;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      taken       <= 1'b0;
      flush_cnt   <= 1'b0;
    end else begin
      case (state_q)
        HALT: begin
          fetch_valid <= 1'b0;
          flush       <= 1'b0;
          taken       <= 1'b0;
        end
        FLUSH: begin
          fetch_valid <= 1'b1;
          taken       <= 1'b0;
          // A stall freezes both the PC and the flush window.
          if (!stall) begin
            PC <= PC + 32'd1;
            if (flush_cnt) begin
              state_q   <= RUN;
              flush     <= 1'b0;
              flush_cnt <= 1'b0;
            end else begin
              flush_cnt <= 1'b1;
            end
          end
        end
        default: begin
          fetch_valid <= 1'b1;
          if (take) begin
            PC        <= target;
            taken     <= 1'b1;
            state_q   <= FLUSH;
            flush     <= 1'b1;
            flush_cnt <= 1'b0;
            if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
          end else begin
            taken <= 1'b0;
            if (!stall) PC <= PC + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 SHALL provide port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL provide port stall, input, 1 bit: hold PC this cycle.
REQ-005 SHALL provide port halt, input, 1 bit: enter HALT state.
REQ-006 SHALL provide port br_valid, input, 1 bit: execute stage presents a branch-class instruction this cycle.
REQ-007 SHALL provide port BS, input, 2 bits: branch select of the presented instruction.
REQ-008 SHALL provide port PS, input, 1 bit: polarity select.
REQ-009 SHALL provide port Z, input, 1 bit: zero flag from the execute stage.
REQ-010 SHALL provide port br_pc_1, input, 32 bits: PC+1 of the branching instruction.
REQ-011 SHALL provide port br_offset, input, 16 bits: signed two's-complement displacement.
REQ-012 SHALL provide port RAA, input, 32 bits: register-A jump target.
REQ-013 SHALL provide port PC, output, 32 bits: fetch address (registered).
REQ-014 SHALL provide port PC_1, output, 32 bits: PC+1 (combinational from PC).
REQ-015 SHALL provide port fetch_valid, output, 1 bit: fetch at PC is live.
REQ-016 SHALL provide port flush, output, 1 bit: kill younger in-flight instructions.
REQ-017 SHALL provide port taken, output, 1 bit: registered pulse marking a redirect.
REQ-018 SHALL provide port taken_cnt, output, 16 bits: saturating count of taken branches.
REQ-019 SHALL provide port state, output, 2 bits: RUN=0, FLUSH=1, HALT=2; value 3 is unused.

Function
REQ-020 SHALL compute BrA = br_pc_1 + sign_extend32(br_offset), modulo 2^32.
REQ-021 SHALL decode the branch from BS as follows; the redirect is "taken" in every case except fall-through:
- 00: fall through to PC+1.
- 01: go to BrA if (PS XOR Z) = 1, otherwise fall through.
- 10: go to RAA unconditionally.
- 11: go to BrA unconditionally.
REQ-022 SHALL evaluate br_valid only in RUN; in FLUSH and HALT, br_valid is ignored because the presented instructions are squashed.
REQ-023 SHALL apply next-PC priority: rst > halt > taken redirect > stall > PC+1.
REQ-024 SHALL, on a taken redirect in RUN, at the edge: load PC with the target, set taken=1 for exactly one cycle, increment taken_cnt, and enter FLUSH.
REQ-025 SHALL, in FLUSH, hold flush=1 for exactly 2 consecutive cycles, counted by an internal 1-bit counter, then return to RUN.
REQ-026 SHALL, in FLUSH, keep fetch_valid=1 and advance PC by 1 per cycle unless stall is high.
REQ-027 SHALL, when stall is high in FLUSH, freeze both PC and the flush counter, so flush stays high until 2 non-stalled FLUSH cycles have elapsed.
REQ-028 SHALL let a taken redirect override a simultaneous stall: PC is loaded regardless of stall.
REQ-029 SHALL, when stall=1 and no redirect occurs, hold PC with fetch_valid=1.
REQ-030 SHALL treat halt=1 in any state as follows at the edge: enter HALT, freeze PC, set fetch_valid=0 and flush=0, and set taken=0; a coincident redirect is discarded.
REQ-031 SHALL leave HALT only via rst.
REQ-032 SHALL wrap PC from 0xFFFFFFFF to 0x00000000 on increment; BrA wraps identically with no overflow flag.
REQ-033 SHALL saturate taken_cnt at 0xFFFF; further taken branches do not change it.
REQ-034 SHALL ensure flush never overlaps HALT and taken is never high in two consecutive cycles.

Reset
REQ-035 SHALL, when rst=1 at an edge, set PC=0x00000000, state=RUN, fetch_valid=0, flush=0, taken=0, taken_cnt=0, and flush counter=0; PC_1 then reads 0x00000001.
REQ-036 SHALL set fetch_valid=1 from the first edge with rst=0 onward.
REQ-037 SHALL let a reset during FLUSH or HALT abandon the operation immediately, with no residual flush or taken pulse.
REQ-038 SHALL take rst priority over every other input.

Verification
REQ-039 SHALL cover: reset, then 3 idle cycles -> PC = 0, 1, 2, 3 with fetch_valid=1 after reset.
REQ-040 SHALL cover: in RUN, BS=01, PS=0, Z=1, br_pc_1=0x10, br_offset=0xFFFC -> next PC=0x0C, taken pulse, flush high 2 cycles, PC 0x0C, 0x0D, 0x0E.
REQ-041 SHALL cover: BS=01, PS=1, Z=1 -> not taken, PC increments, flush=0, taken_cnt unchanged; then BS=10 with RAA=0x8000 and stall=1 -> PC=0x8000.
REQ-042 SHALL cover: PC=0xFFFFFFFF, no branch -> PC=0x00000000; BS=11 with br_pc_1=0xFFFFFFFF and offset=0x0002 -> PC=0x00000001.
REQ-043 SHALL cover: br_valid with BS=11 during FLUSH -> ignored; a stall in FLUSH extends flush to 3 cycles.
REQ-044 SHALL cover: halt together with a taken branch -> HALT, PC frozen, fetch_valid=0, taken_cnt unchanged; then rst -> PC=0, state=RUN.
